fetch_unit: RTL and testbench

- Instruction fetch stage; sits directly upstream of the decode stage.
- Owns the program counter and issues word requests to instruction memory over a valid/ready request channel with an in-order response channel.
- Buffers returned instructions with their PCs in a small FIFO and presents them to decode over a valid/ready handshake.
- Accepts redirects (taken branch/jump) from execute: flushes buffered entries and discards in-flight responses.

---
 rtl/fetch_unit.sv | 162 ++++++++++++++++
 tb/tb_fetch_unit.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, issues in-order word requests and buffers results for decode.
// Optional misaligned-redirect reporting is built when FETCH_MISALIGN_CHECK_EN is defined.
`timescale 1ns/1ps

package core_pkg;
  parameter int Xlen = 32;
  parameter int Ilen = 32;
endpackage

module fetch_unit
  import core_pkg::*;
#(
  parameter logic [Xlen-1:0] ResetPc   = 'h8000_0000,
  parameter int              FifoDepth = 2
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            redirect_valid_i,
  input  logic [Xlen-1:0] redirect_pc_i,
  output logic            imem_req_valid_o,
  input  logic            imem_req_ready_i,
  output logic [Xlen-1:0] imem_req_addr_o,
  input  logic            imem_resp_valid_i,
  input  logic [Ilen-1:0] imem_resp_data_i,
  output logic            instr_valid_o,
  input  logic            instr_ready_i,
  output logic [Ilen-1:0] instr_o,
`ifdef FETCH_MISALIGN_CHECK_EN
  output logic            instr_misalign_o,
`endif
  output logic [Xlen-1:0] instr_pc_o
);

  localparam int PtrW = $clog2(FifoDepth);
  localparam int CntW = $clog2(FifoDepth + 1);

  logic                 started_reg;
  logic [Xlen-1:0]      fetch_pc_reg;
  logic [Xlen-1:0]      entry_pc_reg    [FifoDepth];
  logic [Ilen-1:0]      entry_instr_reg [FifoDepth];
  logic [FifoDepth-1:0] entry_filled_reg;
  logic [PtrW-1:0]      head_reg, tail_reg, fill_reg;
  logic [CntW-1:0]      alloc_cnt_reg, pend_cnt_reg, discard_cnt_reg;

  logic            halted;
  logic            misalign_redirect;
  logic [Xlen-1:0] target_pc;
  logic [CntW-1:0] used_slots;
  logic [CntW-1:0] discard_on_redirect;
  logic            accept, resp_fill, resp_drop, pop, fifo_nonempty;

`ifdef FETCH_MISALIGN_CHECK_EN
  logic                 halted_reg;
  logic [FifoDepth-1:0] entry_misalign_reg;

  assign halted            = halted_reg;
  assign target_pc         = redirect_pc_i;
  assign misalign_redirect = redirect_valid_i && (redirect_pc_i[1:0] != 2'b00);
  assign instr_misalign_o  = instr_valid_o && entry_misalign_reg[head_reg];
`else
  assign halted            = 1'b0;
  assign target_pc         = redirect_pc_i & ~Xlen'(3);
  assign misalign_redirect = 1'b0;
`endif

  // Credits come from registered occupancy plus responses still owed to the discard path.
  assign used_slots       = alloc_cnt_reg + discard_cnt_reg;
  assign imem_req_valid_o = started_reg && (used_slots < CntW'(FifoDepth)) && !redirect_valid_i && !halted;
  assign imem_req_addr_o  = fetch_pc_reg;
  assign accept           = imem_req_valid_o && imem_req_ready_i;

  assign resp_drop = imem_resp_valid_i && (discard_cnt_reg != '0);
  assign resp_fill = imem_resp_valid_i && (discard_cnt_reg == '0) && (pend_cnt_reg != '0);
  assign discard_on_redirect = pend_cnt_reg + discard_cnt_reg
                             - CntW'(imem_resp_valid_i && (pend_cnt_reg != '0 || discard_cnt_reg != '0));

  assign fifo_nonempty = (alloc_cnt_reg != '0);
  assign instr_valid_o = fifo_nonempty && entry_filled_reg[head_reg] && !redirect_valid_i;
  assign instr_o       = fifo_nonempty ? entry_instr_reg[head_reg] : '0;
  assign instr_pc_o    = fifo_nonempty ? entry_pc_reg[head_reg]    : '0;
  assign pop           = instr_valid_o && instr_ready_i;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      started_reg      <= 1'b0;
      fetch_pc_reg     <= ResetPc;
      head_reg         <= '0;
      tail_reg         <= '0;
      fill_reg         <= '0;
      alloc_cnt_reg    <= '0;
      pend_cnt_reg     <= '0;
      discard_cnt_reg  <= '0;
      entry_filled_reg <= '0;
      for (int i = 0; i < FifoDepth; i++) begin
        entry_pc_reg[i]    <= '0;
        entry_instr_reg[i] <= '0;
      end
`ifdef FETCH_MISALIGN_CHECK_EN
      halted_reg         <= 1'b0;
      entry_misalign_reg <= '0;
`endif
    end else begin
      started_reg <= 1'b1;
      if (redirect_valid_i) begin
        fetch_pc_reg     <= target_pc;
        head_reg         <= '0;
        tail_reg         <= '0;
        fill_reg         <= '0;
        alloc_cnt_reg    <= '0;
        pend_cnt_reg     <= '0;
        discard_cnt_reg  <= discard_on_redirect;
        entry_filled_reg <= '0;
`ifdef FETCH_MISALIGN_CHECK_EN
        entry_misalign_reg <= '0;
        halted_reg         <= misalign_redirect;
        // A misaligned target becomes one pre-filled entry that decode sees as a fault.
        if (misalign_redirect) begin
          entry_pc_reg[0]       <= redirect_pc_i;
          entry_instr_reg[0]    <= '0;
          entry_filled_reg[0]   <= 1'b1;
          entry_misalign_reg[0] <= 1'b1;
          tail_reg              <= PtrW'(1);
          fill_reg              <= PtrW'(1);
          alloc_cnt_reg         <= CntW'(1);
        end
`endif
      end else begin
        if (accept) begin
          entry_pc_reg[tail_reg]     <= fetch_pc_reg;
          entry_filled_reg[tail_reg] <= 1'b0;
`ifdef FETCH_MISALIGN_CHECK_EN
          entry_misalign_reg[tail_reg] <= 1'b0;
`endif
          tail_reg     <= tail_reg + 1'b1;
          fetch_pc_reg <= fetch_pc_reg + Xlen'(4);
        end
        // In-order responses always land in the oldest unfilled slot.
        if (resp_fill) begin
          entry_instr_reg[fill_reg]  <= imem_resp_data_i;
          entry_filled_reg[fill_reg] <= 1'b1;
          fill_reg                   <= fill_reg + 1'b1;
        end
        if (resp_drop) begin
          discard_cnt_reg <= discard_cnt_reg - 1'b1;
        end
        if (pop) begin
          head_reg <= head_reg + 1'b1;
        end
        alloc_cnt_reg <= alloc_cnt_reg + CntW'(accept) - CntW'(pop);
        pend_cnt_reg  <= pend_cnt_reg + CntW'(accept) - CntW'(resp_fill);
      end
    end
  end

  wire unused_misalign = misalign_redirect;

`ifndef SYNTHESIS
  resp_has_owner: assert property (@(posedge clk_i) disable iff (!rst_ni)
    imem_resp_valid_i |-> (pend_cnt_reg != '0 || discard_cnt_reg != '0));
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: in-order memory model with settable latency, decode-side capture.
`timescale 1ns/1ps

module tb_fetch_unit;
  localparam logic [31:0] RESET_PC = 32'h8000_0000;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic        redirect_valid_i;
  logic [31:0] redirect_pc_i;
  logic        imem_req_valid_o;
  logic        imem_req_ready_i;
  logic [31:0] imem_req_addr_o;
  logic        imem_resp_valid_i;
  logic [31:0] imem_resp_data_i;
  logic        instr_valid_o;
  logic        instr_ready_i;
  logic [31:0] instr_o;
  logic [31:0] instr_pc_o;

  int checks = 0;
  int failures = 0;
  int mem_lat = 1;
  int acc_cnt = 0;
  int cyc = 0;
  logic [63:0] mq[$];
  logic [31:0] got_pc[$];
  logic [31:0] got_instr[$];

  fetch_unit #(.ResetPc(RESET_PC), .FifoDepth(2)) dut (
    .clk_i            (clk_i),
    .rst_ni           (rst_ni),
    .redirect_valid_i (redirect_valid_i),
    .redirect_pc_i    (redirect_pc_i),
    .imem_req_valid_o (imem_req_valid_o),
    .imem_req_ready_i (imem_req_ready_i),
    .imem_req_addr_o  (imem_req_addr_o),
    .imem_resp_valid_i(imem_resp_valid_i),
    .imem_resp_data_i (imem_resp_data_i),
    .instr_valid_o    (instr_valid_o),
    .instr_ready_i    (instr_ready_i),
    .instr_o          (instr_o),
    .instr_pc_o       (instr_pc_o)
  );

  always #5 clk_i = ~clk_i;

  // Memory: instruction word is the bitwise inverse of its address, returned mem_lat cycles after accept.
  initial begin
    imem_resp_valid_i = 1'b0;
    imem_resp_data_i  = '0;
    forever begin
      @(posedge clk_i);
      cyc++;
      #2;
      if (rst_ni && mq.size() != 0 && mq[0][31:0] <= 32'(cyc)) begin
        imem_resp_valid_i = 1'b1;
        imem_resp_data_i  = ~mq[0][63:32];
      end else begin
        imem_resp_valid_i = 1'b0;
        imem_resp_data_i  = '0;
      end
      @(negedge clk_i);
      if (!rst_ni) begin
        mq.delete();
      end else begin
        if (imem_resp_valid_i) void'(mq.pop_front());
        if (imem_req_valid_o && imem_req_ready_i) mq.push_back({imem_req_addr_o, 32'(cyc + mem_lat)});
      end
    end
  end

  // Decode-side capture and request counter.
  initial begin
    forever begin
      @(negedge clk_i);
      if (rst_ni && instr_valid_o && instr_ready_i) begin
        got_pc.push_back(instr_pc_o);
        got_instr.push_back(instr_o);
      end
      if (rst_ni && imem_req_valid_o && imem_req_ready_i) acc_cnt++;
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_got(input string tag, input int idx, input logic [31:0] pc);
    check($sformatf("%s_present", tag), 32'(idx < got_pc.size()), 32'd1);
    if (idx < got_pc.size()) begin
      check($sformatf("%s_pc", tag), got_pc[idx], pc);
      check($sformatf("%s_instr", tag), got_instr[idx], ~pc);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk_i);
      #1;
    end
  endtask

  task automatic redirect(input logic [31:0] pc);
    @(posedge clk_i); #1;
    redirect_valid_i = 1'b1;
    redirect_pc_i    = pc;
    @(posedge clk_i); #1;
    redirect_valid_i = 1'b0;
  endtask

  initial begin
    int n0;
    int acc0;
    bit found;
    rst_ni           = 1'b0;
    redirect_valid_i = 1'b0;
    redirect_pc_i    = '0;
    imem_req_ready_i = 1'b1;
    instr_ready_i    = 1'b1;

    // Reset values
    step(2);
    @(negedge clk_i);
    check("rst_req_valid", 32'(imem_req_valid_o), 32'd0);
    check("rst_instr_valid", 32'(instr_valid_o), 32'd0);
    check("rst_instr", instr_o, 32'd0);
    check("rst_instr_pc", instr_pc_o, 32'd0);
    check("rst_req_addr", imem_req_addr_o, RESET_PC);

    // Release: request one cycle after the release edge, instruction two cycles later
    @(posedge clk_i); #1;
    rst_ni = 1'b1;
    @(negedge clk_i);
    check("t1_req_before_edge", 32'(imem_req_valid_o), 32'd0);
    @(negedge clk_i);
    check("t1_first_req_valid", 32'(imem_req_valid_o), 32'd1);
    check("t1_first_req_addr", imem_req_addr_o, RESET_PC);
    @(negedge clk_i);
    check("t1_valid_during_resp", 32'(instr_valid_o), 32'd0);
    @(negedge clk_i);
    check("t1_valid_after_fill", 32'(instr_valid_o), 32'd1);
    check("t1_first_pc", instr_pc_o, RESET_PC);
    step(20);
    for (int i = 0; i < 6; i++) check_got($sformatf("t1_seq%0d", i), i, RESET_PC + 32'(4 * i));

    // Decode stall: only FifoDepth requests go out, then nothing lost or duplicated
    @(posedge clk_i); #1;
    instr_ready_i    = 1'b0;
    redirect_valid_i = 1'b1;
    redirect_pc_i    = 32'h8000_0200;
    acc0 = acc_cnt;
    @(posedge clk_i); #1;
    redirect_valid_i = 1'b0;
    n0 = got_pc.size();
    step(5);
    check("t2_req_count", 32'(acc_cnt - acc0), 32'd2);
    check("t2_req_valid_dropped", 32'(imem_req_valid_o), 32'd0);
    check("t2_no_delivery", 32'(got_pc.size() - n0), 32'd0);
    instr_ready_i = 1'b1;
    step(12);
    for (int i = 0; i < 4; i++) check_got($sformatf("t2_seq%0d", i), n0 + i, 32'h8000_0200 + 32'(4 * i));

    // Latency 3, redirect with two requests in flight
    mem_lat = 3;
    redirect(32'h8000_0400);
    found = 1'b0;
    for (int i = 0; i < 30 && !found; i++) begin
      @(posedge clk_i); #3;
      if (mq.size() == 2 && !imem_resp_valid_i) found = 1'b1;
    end
    check("t3_two_in_flight", 32'(found), 32'd1);
    redirect_valid_i = 1'b1;
    redirect_pc_i    = 32'h8000_0100;
    n0 = got_pc.size();
    @(posedge clk_i); #1;
    redirect_valid_i = 1'b0;
    step(20);
    for (int i = 0; i < 3; i++) check_got($sformatf("t3_seq%0d", i), n0 + i, 32'h8000_0100 + 32'(4 * i));

    // Redirect coinciding with a response and a decode handshake
    mem_lat = 1;
    step(4);
    found = 1'b0;
    for (int i = 0; i < 30 && !found; i++) begin
      @(posedge clk_i); #3;
      if (imem_resp_valid_i && instr_valid_o && instr_ready_i) found = 1'b1;
    end
    check("t4_collision_found", 32'(found), 32'd1);
    redirect_valid_i = 1'b1;
    redirect_pc_i    = 32'h8000_0800;
    n0 = got_pc.size();
    @(negedge clk_i);
    check("t4_valid_masked", 32'(instr_valid_o), 32'd0);
    @(posedge clk_i); #1;
    redirect_valid_i = 1'b0;
    check("t4_no_accept", 32'(got_pc.size() - n0), 32'd0);
    step(10);
    for (int i = 0; i < 2; i++) check_got($sformatf("t4_seq%0d", i), n0 + i, 32'h8000_0800 + 32'(4 * i));

    // PC wrap at the top of the address space
    redirect(32'hFFFF_FFF8);
    n0 = got_pc.size();
    step(12);
    check_got("t5_wrap0", n0, 32'hFFFF_FFF8);
    check_got("t5_wrap1", n0 + 1, 32'hFFFF_FFFC);
    check_got("t5_wrap2", n0 + 2, 32'h0000_0000);
    check_got("t5_wrap3", n0 + 3, 32'h0000_0004);

    // Low target bits are ignored when misalign reporting is not built
    redirect(32'h8000_0103);
    n0 = got_pc.size();
    step(8);
    check_got("t5_align", n0, 32'h8000_0100);

    // Asynchronous reset mid-stream
    mem_lat = 3;
    redirect(32'h8000_0C00);
    found = 1'b0;
    for (int i = 0; i < 30 && !found; i++) begin
      @(posedge clk_i); #3;
      if (mq.size() != 0) found = 1'b1;
    end
    check("t6_in_flight", 32'(found), 32'd1);
    rst_ni = 1'b0;
    #1;
    check("t6_req_valid", 32'(imem_req_valid_o), 32'd0);
    check("t6_instr_valid", 32'(instr_valid_o), 32'd0);
    check("t6_instr", instr_o, 32'd0);
    check("t6_instr_pc", instr_pc_o, 32'd0);
    check("t6_req_addr", imem_req_addr_o, RESET_PC);
    step(2);
    mem_lat = 1;
    rst_ni = 1'b1;
    n0 = got_pc.size();
    step(12);
    check_got("t6_restart0", n0, RESET_PC);
    check_got("t6_restart1", n0 + 1, RESET_PC + 32'd4);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
